// File: rtl/bus_debug_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the UART debug bus master.
package bus_debug_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP
  } state_t;

endpackage

// File: rtl/bus_debug_master.sv
// UART byte-stream command decoder that issues single-word picorv32-native bus
// transactions and streams ACK/NAK or little-endian read data back to the host.
module bus_debug_master
  import bus_debug_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  output logic        rx_tready,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] addr_sr;
  logic [31:0] wdata_sr;
  logic [31:0] resp_sr;
  logic [1:0]  byte_cnt;
  logic [15:0] to_cnt;
  logic        is_write;
  logic        resp_wide;
  logic        accept;

  assign accept    = rx_tvalid && rx_tready;
  assign mem_valid = (state == BUS);
  assign mem_instr = 1'b0;
  assign mem_addr  = {addr_sr[31:2], 2'b00};
  assign mem_wdata = wdata_sr;
  assign mem_wstrb = (state == BUS && is_write) ? 4'hF : 4'h0;
  assign tx_tvalid = (state == RESP);
  assign tx_tdata  = resp_sr[7:0];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      rx_tready <= 1'b0;
      err       <= 1'b0;
      addr_sr   <= '0;
      wdata_sr  <= '0;
      resp_sr   <= '0;
      byte_cnt  <= '0;
      to_cnt    <= '0;
      is_write  <= 1'b0;
      resp_wide <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          rx_tready <= 1'b1;
          if (accept) begin
            byte_cnt <= '0;
            if (rx_tdata == OP_WRITE || rx_tdata == OP_READ) begin
              is_write <= (rx_tdata == OP_WRITE);
              state    <= ADDR;
            end else begin
              // Bad opcode: answer NAK without touching the bus
              resp_sr   <= {24'h0, RSP_NAK};
              resp_wide <= 1'b0;
              err       <= 1'b1;
              rx_tready <= 1'b0;
              state     <= RESP;
            end
          end
        end
        ADDR: begin
          if (accept) begin
            addr_sr  <= {rx_tdata, addr_sr[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_write) begin
                state <= DATA;
              end else begin
                rx_tready <= 1'b0;
                to_cnt    <= '0;
                state     <= BUS;
              end
            end
          end
        end
        DATA: begin
          if (accept) begin
            wdata_sr <= {rx_tdata, wdata_sr[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              rx_tready <= 1'b0;
              to_cnt    <= '0;
              state     <= BUS;
            end
          end
        end
        BUS: begin
          // A ready arriving on the timeout cycle still completes normally
          if (mem_ready) begin
            byte_cnt  <= '0;
            state     <= RESP;
            resp_wide <= !is_write;
            resp_sr   <= is_write ? {24'h0, RSP_ACK} : mem_rdata;
          end else if (to_cnt == TO_LAST) begin
            byte_cnt  <= '0;
            state     <= RESP;
            resp_wide <= 1'b0;
            resp_sr   <= {24'h0, RSP_NAK};
            err       <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        RESP: begin
          if (tx_tready) begin
            resp_sr  <= {8'h0, resp_sr[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (!resp_wide || byte_cnt == 2'd3) begin
              rx_tready <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_debug_master.sv
// Directed bench for bus_debug_master: write, read, bad opcode, timeout,
// TX backpressure and asynchronous reset during a bus cycle.
module tb_bus_debug_master;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid;
  logic        rx_tready;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid;
  logic        tx_tready;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  bus_debug_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and return #1 after the edge on which it was accepted.
  task automatic send_byte(input logic [7:0] b);
    logic hs;
    int   n;
    rx_tdata  = b;
    rx_tvalid = 1'b1;
    n = 0;
    do begin
      hs = rx_tready;
      tick();
      n++;
    end while (!hs && n < 50);
    rx_tvalid = 1'b0;
    if (!hs) check("rx_handshake_timeout", 32'(hs), 32'd1);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                          input bit with_data);
    send_byte(op);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    if (with_data) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (!tx_tvalid && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(tx_tdata), 32'(exp));
    tx_tready = 1'b1;
    tick();
    tx_tready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {rx_tready, tx_tvalid, mem_valid, mem_instr, busy, err, mem_wstrb, tx_tdata}, 32'h0);
    check({tag, "_addr"}, mem_addr, 32'h0);
    check({tag, "_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    int     n;
    int     k;
    logic   pat [12];
    logic [7:0] got [4];
    logic [7:0] prev_data;
    logic   prev_stall;

    resetn    = 1'b0;
    rx_tdata  = 8'h0;
    rx_tvalid = 1'b0;
    tx_tready = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    resetn = 1'b1;
    tick();
    check("rx_tready_after_reset", 32'(rx_tready), 32'd1);

    // Write with responder ready after 2 cycles
    send_cmd(8'h57, 32'h00000010, 32'hDEADBEEF, 1'b1);
    check("wr_valid", 32'(mem_valid), 32'd1);
    check("wr_addr", mem_addr, 32'h00000010);
    check("wr_wdata", mem_wdata, 32'hDEADBEEF);
    check("wr_wstrb", 32'(mem_wstrb), 32'hF);
    check("wr_busy_rxrdy", {busy, rx_tready}, 32'b10);
    tick();
    check("wr_hold", {mem_valid, mem_wstrb, mem_addr[7:0]}, {1'b1, 4'hF, 8'h10});
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("wr_valid_drop", 32'(mem_valid), 32'd0);
    check("wr_tx_first", {tx_tvalid, tx_tdata, err}, {1'b1, 8'h06, 1'b0});
    recv_byte("wr_ack", 8'h06);
    check("wr_idle", {busy, tx_tvalid, rx_tready}, 32'b001);

    // Zero-wait read, address low bits dropped
    send_cmd(8'h52, 32'h00000013, 32'h0, 1'b0);
    check("rd_addr", mem_addr, 32'h00000010);
    check("rd_wstrb", {mem_valid, mem_wstrb}, {1'b1, 4'h0});
    mem_ready = 1'b1;
    mem_rdata = 32'h12345678;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    recv_byte("rd_b0", 8'h78);
    recv_byte("rd_b1", 8'h56);
    recv_byte("rd_b2", 8'h34);
    recv_byte("rd_b3", 8'h12);
    check("rd_idle", {busy, tx_tvalid}, 32'b00);

    // Bad opcode
    send_byte(8'h41);
    check("nak_first", {tx_tvalid, tx_tdata, err, mem_valid}, {1'b1, 8'h15, 1'b1, 1'b0});
    tick();
    check("nak_err_pulse", {err, tx_tvalid, tx_tdata}, {1'b0, 1'b1, 8'h15});
    recv_byte("nak_byte", 8'h15);
    send_cmd(8'h52, 32'h00000020, 32'h0, 1'b0);
    check("after_nak_addr", {mem_valid, mem_addr}, {1'b1, 32'h00000020});
    mem_ready = 1'b1;
    mem_rdata = 32'hAABBCCDD;
    tick();
    mem_ready = 1'b0;
    recv_byte("after_nak_b0", 8'hDD);
    recv_byte("after_nak_b1", 8'hCC);
    recv_byte("after_nak_b2", 8'hBB);
    recv_byte("after_nak_b3", 8'hAA);

    // Timeout: mem_valid high exactly 8 cycles
    send_cmd(8'h52, 32'h00000100, 32'h0, 1'b0);
    n = 0;
    while (mem_valid && n < 20) begin
      n++;
      tick();
    end
    check("to_valid_cycles", 32'(n), 32'd8);
    check("to_nak", {tx_tvalid, tx_tdata, err}, {1'b1, 8'h15, 1'b1});
    recv_byte("to_nak_byte", 8'h15);

    // Ready on the final allowed cycle wins
    send_cmd(8'h57, 32'h00000004, 32'h44332211, 1'b1);
    repeat (7) tick();
    check("to_edge_still_valid", 32'(mem_valid), 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("to_edge_ack", {tx_tvalid, tx_tdata, err, mem_valid}, {1'b1, 8'h06, 1'b0, 1'b0});
    recv_byte("to_edge_ack_byte", 8'h06);

    // TX backpressure 1-0-0-1...
    send_cmd(8'h52, 32'h00000030, 32'h0, 1'b0);
    mem_ready = 1'b1;
    mem_rdata = 32'h12345678;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 12; i++) pat[i] = (i % 3 == 0);
    k = 0;
    prev_stall = 1'b0;
    prev_data  = 8'h0;
    for (int i = 0; i < 12; i++) begin
      if (prev_stall) check("bp_stable", 32'({tx_tvalid, tx_tdata}), 32'({1'b1, prev_data}));
      tx_tready = pat[i];
      if (tx_tvalid && tx_tready) begin
        if (k < 4) got[k] = tx_tdata;
        k++;
      end
      prev_stall = tx_tvalid && !tx_tready;
      prev_data  = tx_tdata;
      tick();
    end
    tx_tready = 1'b0;
    check("bp_count", 32'(k), 32'd4);
    check("bp_bytes", {got[0], got[1], got[2], got[3]}, 32'h78563412);

    // Asynchronous reset during BUS
    send_cmd(8'h57, 32'h00000008, 32'hCAFEF00D, 1'b1);
    check("rst_pre_valid", 32'(mem_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("rst_mid_bus");
    @(posedge clk);
    #2;
    resetn = 1'b1;
    tick();
    check("rst_rx_tready", 32'(rx_tready), 32'd1);
    send_cmd(8'h57, 32'h0000000C, 32'h01020304, 1'b1);
    check("post_rst_wr", {mem_valid, mem_wstrb, mem_wdata}, {1'b1, 4'hF, 32'h01020304});
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    recv_byte("post_rst_ack", 8'h06);
    check("post_rst_idle", {busy, mem_valid, tx_tvalid}, 32'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_debug_master.md
# bus_debug_master

Byte-stream-to-bus initiator that lets a host peek and poke the on-chip memory map over the UART. It consumes command bytes from the UART receive stream (AXI-stream, 8-bit), issues single-word transactions on the picorv32-native memory bus (`mem_valid`/`mem_ready`) as an initiator, and returns response bytes on the UART transmit stream. It sits beside the CPU as a second bus master, ahead of an external arbiter. It is the initiator counterpart of the memory/MMIO responder.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: maximum cycles `mem_valid` is held without `mem_ready` before the transaction is aborted; legal range 2..65535.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `resetn` in 1: reset is asynchronous and active-low.
- `rx_tdata` in 8: command byte from UART RX.
- `rx_tvalid` in 1: command byte valid.
- `rx_tready` out 1: block accepts a byte when `rx_tvalid && rx_tready`.
- `tx_tdata` out 8: response byte to UART TX.
- `tx_tvalid` out 1: response byte valid.
- `tx_tready` in 1: UART TX accepts the byte.
- `mem_valid` out 1: bus request.
- `mem_instr` out 1: tied 0.
- `mem_ready` in 1: responder completion.
- `mem_addr` out 32: word address; bits [1:0] always 0.
- `mem_wdata` out 32: write data.
- `mem_wstrb` out 4: 4'hF for writes, 4'h0 for reads.
- `mem_rdata` in 32: read data, valid in the cycle `mem_ready` is high.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: one-cycle pulse on NAK (bad opcode or timeout).

## Operation
- Command format, multi-byte fields little-endian:
  - `0x57` ('W'): addr[4], data[4]. Response: `0x06` (ACK).
  - `0x52` ('R'): addr[4]. Response: rdata[4], little-endian.
  - Any other opcode: response `0x15` (NAK) and `err` pulse. No bus cycle.
- Address bits [1:0] from the host are discarded.
- States:
  - IDLE: on opcode, go to ADDR (W/R) or RESP with NAK.
  - ADDR: 4 bytes; byte counter 2-bit, wraps 3->0. Go to DATA (W) or BUS (R).
  - DATA: 4 bytes, then BUS.
  - BUS: hold `mem_valid`/`mem_addr`/`mem_wdata`/`mem_wstrb` stable until `mem_ready` or timeout. Then go to RESP.
  - RESP: emit 1 byte (ACK/NAK) or 4 bytes (read data), then IDLE.
- Timeout in BUS:
  - Counter is cleared on BUS entry and increments each cycle `mem_ready`=0.
  - When the counter reaches TIMEOUT_CYCLES-1 with `mem_ready`=0, drop `mem_valid`, pulse `err`, and respond NAK.
  - `mem_ready` arriving in the same cycle as the timeout wins: success path.
- Read data is captured into the response shift register on the `mem_valid && mem_ready` edge.
- `rx_tready`=1 only in IDLE/ADDR/DATA. Bytes are never dropped; a byte arriving in BUS/RESP waits.

## Timing
- Reset values: `rx_tready`=0, `tx_tvalid`=0, `tx_tdata`=0, `mem_valid`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `busy`=0, `err`=0. State=IDLE.
- `rx_tready` goes to 1 in the first cycle after reset release.
- `mem_valid` rises in the cycle after the last command byte handshake.
- `mem_valid` falls in the cycle after the edge where `mem_valid && mem_ready` is sampled. This is compatible with responders that register `mem_ready` and gate it with `!mem_ready`.
- First `tx_tvalid` is asserted the cycle after bus completion or timeout.
- Each response byte is held stable while `tx_tvalid && !tx_tready`. The next byte is presented in the cycle after each handshake.
- IDLE is re-entered the cycle after the final TX handshake. A new opcode can be accepted in that cycle.
- Minimum write turnaround with zero-wait `mem_ready`: 9 RX handshakes + 1 BUS cycle + 1 TX byte.
- Asynchronous reset asserted mid-command or mid-bus-cycle: all outputs take reset values immediately and the partial command is discarded. `mem_valid` dropping without `mem_ready` is permitted only under reset.

## Structure
- Shared package `bus_debug_pkg` holds:
  - opcodes `OP_WRITE`=8'h57 and `OP_READ`=8'h52;
  - `RSP_ACK`=8'h06 and `RSP_NAK`=8'h15;
  - state enum {IDLE, ADDR, DATA, BUS, RESP}.
- Single module; no sub-module. Datapath: 32-bit addr, wdata and resp shift registers, plus a 2-bit byte counter and a 16-bit timeout counter.

## Test plan
- Write: RX 57 10 00 00 00 EF BE AD DE, responder ready after 2 cycles -> one bus write, `mem_addr`=0x00000010, `mem_wdata`=0xDEADBEEF, `mem_wstrb`=F; TX 06.
- Read: RX 52 13 00 00 00, `mem_rdata`=0x12345678 -> `mem_addr`=0x00000010, `mem_wstrb`=0; TX 78 56 34 12.
- Bad opcode: RX 41 -> TX 15, `err` pulse of 1 cycle, `mem_valid` never asserted; following RX 52 … executes normally.
- Timeout: TIMEOUT_CYCLES=8, `mem_ready` held 0 -> `mem_valid` high exactly 8 cycles, then TX 15 and `err` pulse. Repeat with `mem_ready` in cycle 8 -> ACK.
- Backpressure: read with `tx_tready` toggling 1-0-0-1… -> bytes 78 56 34 12 in order, each stable while stalled, no duplicates.
- Reset mid-BUS: assert `resetn`=0 while `mem_valid`=1 -> all outputs 0 in the same cycle; after release, a fresh write completes with ACK.
